// File: rtl/aes_pkg.sv
// +----------------------------------------------------------------------------+
// | aes_pkg                                                                    |
// | Shared AES types, S-box table, xtime helper and key-schedule FSM states.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package aes_pkg;

  typedef logic [0:31]  aes_word_t;
  typedef logic [0:127] aes_block_t;

  typedef enum logic [1:0] {
    KS_IDLE   = 2'd0,
    KS_EXPAND = 2'd1,
    KS_DONE   = 2'd2
  } ks_state_e;

  // Entry n occupies bits [8n : 8n+7]
  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[int'(b)*8 +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_sub_word.sv
// +----------------------------------------------------------------------------+
// | aes_sub_word                                                               |
// | Combinational SubWord: four parallel S-box lookups on one 32-bit word.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module aes_sub_word
  import aes_pkg::*;
(
  input  aes_word_t i_word,
  output aes_word_t o_word
);

  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign o_word[8*b +: 8] = sbox(i_word[8*b +: 8]);
  end

endmodule

`default_nettype wire

// File: rtl/aes_key_sched_iter.sv
// +----------------------------------------------------------------------------+
// | aes_key_sched_iter                                                         |
// | Iterative AES-128/192/256 key expansion, one schedule word per clock,      |
// | with an internal word store and a registered round-key read port.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module aes_key_sched_iter
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                key_valid,
  output logic                key_ready,
  input  logic [0:KEY_BITS-1] key_in,
  output logic                busy,
  output logic                sched_valid,
  input  logic [3:0]          rk_rd_idx,
  output aes_block_t          rk_rd_data
);

  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_key_sched_iter: KEY_BITS must be 128, 192 or 256");
  end

  ks_state_e  r_state;
  ks_state_e  w_state_nxt;
  logic [5:0] r_i;
  logic [2:0] r_phase;
  logic [7:0] r_rcon;
  aes_word_t  r_w [NW];
  aes_block_t r_rd_data;

  logic       w_accept;
  aes_word_t  w_prev;
  aes_word_t  w_back;
  aes_word_t  w_sub_in;
  aes_word_t  w_sub_out;
  aes_word_t  w_t;
  aes_word_t  w_new;
  logic [5:0] w_rd_base;

  assign w_accept = key_valid && key_ready;
  assign w_prev   = r_w[r_i - 6'd1];
  assign w_back   = r_w[r_i - 6'(NK)];

  // One S-box bank serves both the RotWord path and the NK=8 mid-block path
  assign w_sub_in = (r_phase == 3'd0) ? {w_prev[8:31], w_prev[0:7]} : w_prev;

  aes_sub_word u_sub_word (
    .i_word (w_sub_in),
    .o_word (w_sub_out)
  );

  always_comb begin
    w_t = w_prev;
    if (r_phase == 3'd0)
      w_t = w_sub_out ^ {r_rcon, 24'h000000};
    else if (NK == 8 && r_phase == 3'd4)
      w_t = w_sub_out;
  end

  assign w_new = w_back ^ w_t;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= KS_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      KS_IDLE:   if (key_valid) w_state_nxt = KS_EXPAND;
      KS_EXPAND: if (r_i == 6'(NW - 1)) w_state_nxt = KS_DONE;
      KS_DONE:   if (key_valid) w_state_nxt = KS_EXPAND;
      default:   w_state_nxt = KS_IDLE;
    endcase
  end

  always_comb begin
    key_ready   = (r_state == KS_IDLE) || (r_state == KS_DONE);
    busy        = (r_state == KS_EXPAND);
    sched_valid = (r_state == KS_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i     <= '0;
      r_phase <= '0;
      r_rcon  <= 8'h01;
    end else if (w_accept) begin
      r_i     <= 6'(NK);
      r_phase <= '0;
      r_rcon  <= 8'h01;
    end else if (r_state == KS_EXPAND) begin
      if (r_i != 6'(NW)) r_i <= r_i + 6'd1;
      r_phase <= (r_phase == 3'(NK - 1)) ? 3'd0 : r_phase + 3'd1;
      // Hold at the final constant so rcon stays within the legal sequence
      if (r_phase == 3'd0 && r_rcon != 8'h36) r_rcon <= xtime(r_rcon);
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int j = 0; j < NK; j++) r_w[j] <= key_in[32*j +: 32];
    end else if (r_state == KS_EXPAND) begin
      r_w[r_i] <= w_new;
    end
  end

  assign w_rd_base = {rk_rd_idx, 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_rd_data <= '0;
    else if (sched_valid && rk_rd_idx <= 4'(NR))
      r_rd_data <= {r_w[w_rd_base], r_w[w_rd_base + 6'd1],
                    r_w[w_rd_base + 6'd2], r_w[w_rd_base + 6'd3]};
    else
      r_rd_data <= '0;
  end

  assign rk_rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: tb/tb_aes_key_sched_iter.sv
// +----------------------------------------------------------------------------+
// | tb_aes_key_sched_iter                                                      |
// | Self-checking bench: one engine per key size against a FIPS-197 model.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_aes_key_sched_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        kv  [3];
  logic [0:255] kin [3];
  logic        kr  [3];
  logic        bz  [3];
  logic        sv  [3];
  logic [3:0]  idx [3];
  logic [0:127] rd [3];

  int checks = 0;
  int errors = 0;

  logic [7:0]  tb_sbox [256];
  logic [31:0] ref_w   [60];

  localparam logic [0:255] VEC128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [0:255] VEC192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [0:255] VEC256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  always #5 clk = ~clk;

  aes_key_sched_iter #(.KEY_BITS(128)) u_dut128 (
    .clk(clk), .rst_n(rst_n), .key_valid(kv[0]), .key_ready(kr[0]), .key_in(kin[0][0:127]),
    .busy(bz[0]), .sched_valid(sv[0]), .rk_rd_idx(idx[0]), .rk_rd_data(rd[0]));

  aes_key_sched_iter #(.KEY_BITS(192)) u_dut192 (
    .clk(clk), .rst_n(rst_n), .key_valid(kv[1]), .key_ready(kr[1]), .key_in(kin[1][0:191]),
    .busy(bz[1]), .sched_valid(sv[1]), .rk_rd_idx(idx[1]), .rk_rd_data(rd[1]));

  aes_key_sched_iter #(.KEY_BITS(256)) u_dut256 (
    .clk(clk), .rst_n(rst_n), .key_valid(kv[2]), .key_ready(kr[2]), .key_in(kin[2]),
    .busy(bz[2]), .sched_valid(sv[2]), .rk_rd_idx(idx[2]), .rk_rd_data(rd[2]));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference S-box from GF(2^8) inversion plus the affine transform
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [15:0] d = {v, v};
    return d[15-n -: 8];
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      tb_sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {tb_sbox[v[31:24]], tb_sbox[v[23:16]], tb_sbox[v[15:8]], tb_sbox[v[7:0]]};
  endfunction

  task automatic compute_ref(input int nk, input logic [0:255] key);
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    int nw = 4 * (nk + 7);
    for (int j = 0; j < nk; j++) ref_w[j] = key[32*j +: 32];
    for (int i = nk; i < nw; i++) begin
      t = ref_w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        t = subw(t);
      end
      ref_w[i] = ref_w[i-nk] ^ t;
    end
  endtask

  task automatic start_key(input int sz, input logic [0:255] key);
    @(negedge clk);
    kin[sz] = key;
    kv[sz]  = 1'b1;
    @(posedge clk); #1;
    kv[sz]  = 1'b0;
  endtask

  // Called in cycle 1 after the handshake; returns when sched_valid rises
  task automatic wait_valid(input int sz, input string tag);
    int nk  = 4 + 2 * sz;
    int cyc = 1;
    chk({tag, "_busy"},  128'(bz[sz]), 128'd1);
    chk({tag, "_ready"}, 128'(kr[sz]), 128'd0);
    chk({tag, "_svlow"}, 128'(sv[sz]), 128'd0);
    while (!sv[sz] && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_latency"}, 128'(cyc), 128'(4 * (nk + 7) - nk + 1));
  endtask

  task automatic read_rk(input int sz, input int k, output logic [0:127] v);
    idx[sz] = 4'(k);
    @(posedge clk); #1;
    v = rd[sz];
  endtask

  task automatic read_all(input int sz, input string tag);
    logic [0:127] v;
    for (int k = 0; k <= 10 + 2 * sz; k++) begin
      read_rk(sz, k, v);
      chk($sformatf("%s_rk%0d", tag, k), v,
          {ref_w[4*k], ref_w[4*k+1], ref_w[4*k+2], ref_w[4*k+3]});
    end
  endtask

  initial begin
    logic [0:127] v;
    logic [0:255] kb;
    int cyc;

    rst_n = 1'b0;
    for (int s = 0; s < 3; s++) begin
      kv[s] = 1'b0; kin[s] = '0; idx[s] = '0;
    end
    build_sbox();
    #12;
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("rst_ready%0d", s), 128'(kr[s]), 128'd1);
      chk($sformatf("rst_busy%0d", s),  128'(bz[s]), 128'd0);
      chk($sformatf("rst_sv%0d", s),    128'(sv[s]), 128'd0);
      chk($sformatf("rst_rd%0d", s),    rd[s], 128'd0);
    end
    @(negedge clk); rst_n = 1'b1;

    // FIPS-197 vectors for each key size
    compute_ref(4, VEC128); start_key(0, VEC128); wait_valid(0, "v128"); read_all(0, "v128");
    read_rk(0, 1, v);  chk("v128_w4", 128'(v[0:31]), 128'h0a0fafe17);
    read_rk(0, 10, v); chk("v128_rk10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    read_rk(0, 15, v); chk("v128_idx15", v, 128'd0);
    read_rk(0, 0, v);  chk("v128_idx0", v, VEC128[0:127]);

    compute_ref(6, VEC192); start_key(1, VEC192); wait_valid(1, "v192"); read_all(1, "v192");
    read_rk(1, 1, v);  chk("v192_w6", 128'(v[64:95]), 128'hfe0c91f7);
    read_rk(1, 12, v); chk("v192_rk12", v, 128'he98ba06f448c773c8ecc720401002202);
    read_rk(1, 13, v); chk("v192_idx13", v, 128'd0);

    compute_ref(8, VEC256); start_key(2, VEC256); wait_valid(2, "v256"); read_all(2, "v256");
    read_rk(2, 2, v);  chk("v256_w8", 128'(v[0:31]), 128'h9ba35411);
    read_rk(2, 14, v); chk("v256_rk14", v, 128'hfe4890d1e6188d0b046df344706c631e);

    // Random keys, DONE -> new handshake each time
    for (int s = 0; s < 3; s++) begin
      for (int r = 0; r < 3; r++) begin
        kb = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        compute_ref(4 + 2 * s, kb);
        start_key(s, kb);
        wait_valid(s, $sformatf("rnd%0d_%0d", s, r));
        read_all(s, $sformatf("rnd%0d_%0d", s, r));
      end
    end

    // key_valid held with a different key throughout expansion
    kb = {$urandom, $urandom, $urandom, $urandom, 128'h0};
    compute_ref(4, VEC128);
    @(negedge clk); kin[0] = VEC128; kv[0] = 1'b1;
    @(posedge clk); #1;
    kin[0] = kb;
    cyc = 1;
    chk("hold_ready", 128'(kr[0]), 128'd0);
    while (!sv[0] && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 20) chk("hold_ready_mid", 128'(kr[0]), 128'd0);
    end
    kv[0] = 1'b0;
    chk("hold_latency", 128'(cyc), 128'd41);
    read_all(0, "hold");
    compute_ref(4, kb); start_key(0, kb); wait_valid(0, "second"); read_all(0, "second");

    // Async reset mid-expansion; 192 engine parked on a nonzero read
    idx[1] = 4'd1;
    start_key(0, VEC128);
    repeat (19) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", 128'(kr[0]), 128'd1);
    chk("arst_busy",  128'(bz[0]), 128'd0);
    chk("arst_sv",    128'(sv[0]), 128'd0);
    chk("arst_rd192", rd[1], 128'd0);
    chk("arst_sv192", 128'(sv[1]), 128'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      read_rk(0, k, v);
      chk($sformatf("arst_rd%0d", k), v, 128'd0);
    end
    chk("arst_idle_sv", 128'(sv[0]), 128'd0);
    compute_ref(4, VEC128); start_key(0, VEC128); wait_valid(0, "restart"); read_all(0, "restart");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
